// File: rtl/serial_fifo_pkg.sv
// Shared defaults, index-width helper and register-map status packing
// for the serial-port FIFO family.
package serial_fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 9;
  localparam int FIFO_DEPTH_DEF = 16;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic full;
    logic empty;
    logic at_thresh;
  } fifo_status_t;

  // One extra bit beyond the address gives the wrap bit that separates full from empty
  function automatic int fifo_iw(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port storage: one write port, one registered read port.
// Only the read register is reset; the array itself is never cleared.
module fifo_ram_sdp #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-before-write, so a pop of the head while full returns the old word
  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_wm.sv
// Parametrised synchronous FIFO with sticky error flags, threshold flag and
// high-water mark; the watermark register exists only with SYNC_FIFO_WATERMARK_EN.
module sync_fifo_wm
  import serial_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF,
  localparam int IW = fifo_iw(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_request,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_request,
  output logic [WIDTH-1:0] rd_data,
  input  logic             clear_overflow_request,
  input  logic             clear_underflow_request,
  input  logic             clear_watermark_request,
  input  logic [IW-1:0]    thresh,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic             at_thresh,
  output logic [IW-1:0]    count,
  output logic [IW-1:0]    wr_index,
  output logic [IW-1:0]    rd_index,
  output logic [IW-1:0]    watermark
);

  localparam int AW = IW - 1;

  logic          wr_accept;
  logic          rd_accept;
  logic [IW-1:0] wr_index_next;
  logic [IW-1:0] rd_index_next;

  assign empty     = (wr_index == rd_index);
  assign full      = (wr_index == {~rd_index[IW-1], rd_index[AW-1:0]});
  assign count     = wr_index - rd_index;
  assign at_thresh = (count >= thresh);

  // A pop in the same cycle frees the slot, so a write while full is still taken
  assign wr_accept = wr_request && (!full || rd_request);
  assign rd_accept = rd_request && !empty;

  assign wr_index_next = wr_accept ? wr_index + IW'(1) : wr_index;
  assign rd_index_next = rd_accept ? rd_index + IW'(1) : rd_index;

  fifo_ram_sdp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_accept),
    .wr_addr (wr_index[AW-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_accept),
    .rd_addr (rd_index[AW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_index <= '0;
      rd_index <= '0;
    end else begin
      wr_index <= wr_index_next;
      rd_index <= rd_index_next;
    end
  end

  // Set takes priority over clear so a coincident error is never lost
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_request && full && !rd_request) overflow <= 1'b1;
      else if (clear_overflow_request)       overflow <= 1'b0;
      if (rd_request && empty)               underflow <= 1'b1;
      else if (clear_underflow_request)      underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_WATERMARK_EN
  logic [IW-1:0] count_next;
  logic [IW-1:0] watermark_q;

  assign count_next = wr_index_next - rd_index_next;

  always_ff @(posedge clk) begin
    if (reset)                        watermark_q <= '0;
    else if (clear_watermark_request) watermark_q <= count_next;
    else if (count_next > watermark_q) watermark_q <= count_next;
  end

  assign watermark = watermark_q;
`else
  logic unused_clear_watermark;

  assign unused_clear_watermark = clear_watermark_request;
  assign watermark              = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_wm.sv
// Randomised self-checking bench for sync_fifo_wm against a queue-based model;
// watermark expectations follow SYNC_FIFO_WATERMARK_EN.
module tb_sync_fifo_wm;

  localparam int WIDTH = 9;
  localparam int DEPTH = 16;
  localparam int IW    = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_request;
  logic [WIDTH-1:0] wr_data;
  logic             rd_request;
  logic [WIDTH-1:0] rd_data;
  logic             clear_overflow_request;
  logic             clear_underflow_request;
  logic             clear_watermark_request;
  logic [IW-1:0]    thresh;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
  logic             at_thresh;
  logic [IW-1:0]    count;
  logic [IW-1:0]    wr_index;
  logic [IW-1:0]    rd_index;
  logic [IW-1:0]    watermark;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: contents as a queue, indices as operation tallies
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_rd_data;
  int               m_wr_cnt;
  int               m_rd_cnt;
  bit               m_ovf;
  bit               m_udf;
  int               m_wm;

  always #5 clk = ~clk;

  sync_fifo_wm #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .wr_request              (wr_request),
    .wr_data                 (wr_data),
    .rd_request              (rd_request),
    .rd_data                 (rd_data),
    .clear_overflow_request  (clear_overflow_request),
    .clear_underflow_request (clear_underflow_request),
    .clear_watermark_request (clear_watermark_request),
    .thresh                  (thresh),
    .empty                   (empty),
    .full                    (full),
    .overflow                (overflow),
    .underflow               (underflow),
    .at_thresh               (at_thresh),
    .count                   (count),
    .wr_index                (wr_index),
    .rd_index                (rd_index),
    .watermark               (watermark)
  );

  function automatic int exp_wm();
`ifdef SYNC_FIFO_WATERMARK_EN
    return m_wm;
`else
    return 0;
`endif
  endfunction

  task automatic apply_stimulus(input bit rst, input bit wr, input logic [WIDTH-1:0] data,
                                input bit rd, input bit c_ovf, input bit c_udf, input bit c_wm);
    bit was_full, was_empty;
    reset                   = rst;
    wr_request              = wr;
    wr_data                 = data;
    rd_request              = rd;
    clear_overflow_request  = c_ovf;
    clear_underflow_request = c_udf;
    clear_watermark_request = c_wm;
    if (rst) begin
      m_q.delete();
      m_wr_cnt  = 0;
      m_rd_cnt  = 0;
      m_ovf     = 0;
      m_udf     = 0;
      m_wm      = 0;
      m_rd_data = '0;
    end else begin
      was_full  = (m_q.size() == DEPTH);
      was_empty = (m_q.size() == 0);
      if (rd && !was_empty) begin
        m_rd_data = m_q.pop_front();
        m_rd_cnt++;
      end
      if (wr && (!was_full || rd)) begin
        m_q.push_back(data);
        m_wr_cnt++;
      end
      if (wr && was_full && !rd) m_ovf = 1;
      else if (c_ovf)            m_ovf = 0;
      if (rd && was_empty)       m_udf = 1;
      else if (c_udf)            m_udf = 0;
      if (c_wm)                  m_wm = m_q.size();
      else if (m_q.size() > m_wm) m_wm = m_q.size();
    end
    @(posedge clk);
    #1;
    reset                   = 1'b0;
    wr_request              = 1'b0;
    rd_request              = 1'b0;
    clear_overflow_request  = 1'b0;
    clear_underflow_request = 1'b0;
    clear_watermark_request = 1'b0;
  endtask

  task automatic test_reset();
    thresh = '0;
    apply_stimulus(1, 1, 9'h0AB, 1, 0, 0, 0);
    vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b expected 1", empty); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b expected 0", full); end
    vectors++; if (overflow !== 1'b0 || underflow !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got ovf=%b udf=%b expected 0 0", overflow, underflow); end
    vectors++; if (wr_index !== 5'd0 || rd_index !== 5'd0) begin miscompares++; $display("FAIL reset_index: got wr=%0h rd=%0h expected 0 0", wr_index, rd_index); end
    vectors++; if (watermark !== 5'd0) begin miscompares++; $display("FAIL reset_watermark: got %0d expected 0", watermark); end
    vectors++; if (rd_data !== 9'h000) begin miscompares++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
    vectors++; if (at_thresh !== 1'b1) begin miscompares++; $display("FAIL reset_at_thresh0: got %b expected 1", at_thresh); end
    thresh = 5'd5;
    #1;
    vectors++; if (at_thresh !== 1'b0) begin miscompares++; $display("FAIL reset_at_thresh5: got %b expected 0", at_thresh); end
    thresh = '0;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) apply_stimulus(0, 1, 9'(i), 0, 0, 0, 0);
    vectors++; if (full !== 1'b1 || empty !== 1'b0) begin miscompares++; $display("FAIL fill_full: got full=%b empty=%b expected 1 0", full, empty); end
    vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL fill_count: got %0d expected 16", count); end
    vectors++; if (wr_index !== 5'h10 || rd_index !== 5'h00) begin miscompares++; $display("FAIL fill_index: got wr=%0h rd=%0h expected 10 0", wr_index, rd_index); end
    vectors++; if (watermark !== IW'(exp_wm())) begin miscompares++; $display("FAIL fill_watermark: got %0d expected %0d", watermark, exp_wm()); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fill_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_overflow();
    apply_stimulus(0, 1, 9'h1FF, 0, 0, 0, 0);
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    vectors++; if (count !== 5'd16 || wr_index !== 5'h10) begin miscompares++; $display("FAIL ovf_hold: got count=%0d wr=%0h expected 16 10", count, wr_index); end
    for (int i = 1; i <= DEPTH; i++) begin
      apply_stimulus(0, 0, '0, 1, 0, 0, 0);
      vectors++; if (rd_data !== 9'(i)) begin miscompares++; $display("FAIL ovf_drain_data: got %0h expected %0h", rd_data, 9'(i)); end
    end
    vectors++; if (empty !== 1'b1 || rd_index !== 5'h10) begin miscompares++; $display("FAIL ovf_drained: got empty=%b rd=%0h expected 1 10", empty, rd_index); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    apply_stimulus(0, 0, '0, 0, 1, 0, 0);
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_underflow();
    apply_stimulus(0, 0, '0, 1, 0, 0, 0);
    vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL udf_set: got %b expected 1", underflow); end
    vectors++; if (rd_data !== 9'h010 || rd_index !== 5'h10) begin miscompares++; $display("FAIL udf_hold: got data=%0h rd=%0h expected 10 10", rd_data, rd_index); end
    apply_stimulus(0, 0, '0, 0, 0, 1, 0);
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL udf_clear: got %b expected 0", underflow); end
    apply_stimulus(0, 1, 9'h055, 1, 0, 1, 0);
    vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL udf_set_wins: got %b expected 1", underflow); end
    vectors++; if (count !== 5'd1 || rd_data !== 9'h010) begin miscompares++; $display("FAIL udf_push: got count=%0d data=%0h expected 1 10", count, rd_data); end
    apply_stimulus(0, 0, '0, 1, 0, 1, 0);
    vectors++; if (rd_data !== 9'h055 || empty !== 1'b1) begin miscompares++; $display("FAIL udf_pop: got data=%0h empty=%b expected 55 1", rd_data, empty); end
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL udf_clear2: got %b expected 0", underflow); end
  endtask

  task automatic test_full_rw();
    logic [WIDTH-1:0] head;
    for (int i = 0; i < DEPTH; i++) apply_stimulus(0, 1, 9'($urandom), 0, 0, 0, 0);
    head = m_q[0];
    apply_stimulus(0, 1, 9'h0AA, 1, 0, 0, 0);
    vectors++; if (rd_data !== head) begin miscompares++; $display("FAIL fullrw_head: got %0h expected %0h", rd_data, head); end
    vectors++; if (count !== 5'd16 || full !== 1'b1) begin miscompares++; $display("FAIL fullrw_count: got count=%0d full=%b expected 16 1", count, full); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fullrw_overflow: got %b expected 0", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(0, 0, '0, 1, 0, 0, 0);
      vectors++; if (rd_data !== m_rd_data) begin miscompares++; $display("FAIL fullrw_drain: got %0h expected %0h", rd_data, m_rd_data); end
    end
    vectors++; if (rd_data !== 9'h0AA || empty !== 1'b1) begin miscompares++; $display("FAIL fullrw_last: got data=%0h empty=%b expected aa 1", rd_data, empty); end
  endtask

  task automatic test_thresh();
    thresh = 5'd4;
    for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 9'($urandom), 0, 0, 0, 0);
    vectors++; if (at_thresh !== 1'b0) begin miscompares++; $display("FAIL thresh_below: got %b expected 0", at_thresh); end
    apply_stimulus(0, 1, 9'($urandom), 0, 0, 0, 0);
    vectors++; if (at_thresh !== 1'b1) begin miscompares++; $display("FAIL thresh_reach: got %b expected 1", at_thresh); end
    apply_stimulus(0, 0, '0, 1, 0, 0, 0);
    apply_stimulus(0, 0, '0, 1, 0, 0, 0);
    vectors++; if (count !== 5'd2 || at_thresh !== 1'b0) begin miscompares++; $display("FAIL thresh_pop: got count=%0d at=%b expected 2 0", count, at_thresh); end
    apply_stimulus(0, 0, '0, 0, 0, 0, 1);
    vectors++; if (watermark !== IW'(exp_wm())) begin miscompares++; $display("FAIL thresh_wm_clear: got %0d expected %0d", watermark, exp_wm()); end
    thresh = 5'd17;
    #1;
    vectors++; if (at_thresh !== 1'b0) begin miscompares++; $display("FAIL thresh_above_depth: got %b expected 0", at_thresh); end
    thresh = 5'd0;
    #1;
    vectors++; if (at_thresh !== 1'b1) begin miscompares++; $display("FAIL thresh_zero: got %b expected 1", at_thresh); end
  endtask

  task automatic test_back_to_back();
    int level;
    level = m_q.size();
    for (int i = 0; i < 30; i++) begin
      apply_stimulus(0, 1, 9'($urandom), 1, 0, 0, 0);
      vectors++; if (rd_data !== m_rd_data) begin miscompares++; $display("FAIL b2b_data: got %0h expected %0h", rd_data, m_rd_data); end
      vectors++; if (count !== IW'(level)) begin miscompares++; $display("FAIL b2b_count: got %0d expected %0d", count, level); end
    end
  endtask

  task automatic test_random_reset();
    bit wr, rd;
    for (int i = 0; i < 40; i++) begin
      thresh = 5'($urandom_range(0, 17));
      wr = ($urandom_range(0, 99) < 60);
      rd = ($urandom_range(0, 99) < 45);
      apply_stimulus(i == 20, wr, 9'($urandom), rd, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      if (i == 20) begin
        vectors++; if (count !== 5'd0 || empty !== 1'b1 || rd_data !== 9'h000) begin miscompares++; $display("FAIL rnd_reset: got count=%0d empty=%b data=%0h expected 0 1 0", count, empty, rd_data); end
      end
      vectors++; if (count !== IW'(m_q.size())) begin miscompares++; $display("FAIL rnd_count: got %0d expected %0d", count, m_q.size()); end
      vectors++; if (empty !== (m_q.size() == 0) || full !== (m_q.size() == DEPTH)) begin miscompares++; $display("FAIL rnd_empty_full: got %b%b expected %b%b", empty, full, m_q.size() == 0, m_q.size() == DEPTH); end
      vectors++; if (wr_index !== IW'(m_wr_cnt % 32) || rd_index !== IW'(m_rd_cnt % 32)) begin miscompares++; $display("FAIL rnd_index: got wr=%0h rd=%0h expected %0h %0h", wr_index, rd_index, m_wr_cnt % 32, m_rd_cnt % 32); end
      vectors++; if (overflow !== m_ovf || underflow !== m_udf) begin miscompares++; $display("FAIL rnd_flags: got ovf=%b udf=%b expected %b %b", overflow, underflow, m_ovf, m_udf); end
      vectors++; if (rd_data !== m_rd_data) begin miscompares++; $display("FAIL rnd_data: got %0h expected %0h", rd_data, m_rd_data); end
      vectors++; if (watermark !== IW'(exp_wm())) begin miscompares++; $display("FAIL rnd_watermark: got %0d expected %0d", watermark, exp_wm()); end
      vectors++; if (at_thresh !== (m_q.size() >= int'(thresh))) begin miscompares++; $display("FAIL rnd_at_thresh: got %b expected %b", at_thresh, m_q.size() >= int'(thresh)); end
    end
  endtask

  initial begin
    reset                   = 1'b0;
    wr_request              = 1'b0;
    wr_data                 = '0;
    rd_request              = 1'b0;
    clear_overflow_request  = 1'b0;
    clear_underflow_request = 1'b0;
    clear_watermark_request = 1'b0;
    thresh                  = '0;
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_full_rw();
    test_thresh();
    test_back_to_back();
    test_random_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
